// File: rtl/alu_vec_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_vec_sequencer_if
// Command/response bundle between upstream control logic and the ALU
// sequencer.
//   cmd_valid/cmd_ready   : command handshake
//   cmd_a/cmd_b/cmd_sel   : lane-packed operands and ALU opcode
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data/rsp_carry    : captured ALU result and per-lane carry
//   rsp_gt/rsp_eq/rsp_lt  : captured per-lane compare flags
// Modports: master = upstream control, slave = sequencer.
// ---------------------------------------------------------------------------
interface alu_vec_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int n_alu = 4,
    parameter int SEL_W = 3
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [n_alu*WIDTH-1:0]   cmd_a;
    logic [n_alu*WIDTH-1:0]   cmd_b;
    logic [SEL_W-1:0]         cmd_sel;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [n_alu*WIDTH-1:0]   rsp_data;
    logic [n_alu-1:0]         rsp_carry;
    logic [n_alu-1:0]         rsp_gt;
    logic [n_alu-1:0]         rsp_eq;
    logic [n_alu-1:0]         rsp_lt;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_gt, rsp_eq, rsp_lt
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_gt, rsp_eq, rsp_lt
    );
endinterface

// File: rtl/alu_vec_sequencer.sv
// ---------------------------------------------------------------------------
// alu_vec_sequencer
// Command-side driver for the vector ALU. Takes one command at a time,
// presents it to the ALU with a single-cycle enable, waits the ALU pipeline
// latency, captures the result and flags, and hands them back upstream.
//
// Ports:
//   clk          : rising-edge clock
//   arst         : asynchronous active-low reset
//   cmd_rsp      : command/response handshakes (slave side)
//   alu_a/alu_b  : operands to the ALU, held between commands
//   alu_select   : opcode to the ALU, held between commands
//   alu_enable   : one-cycle strobe to the ALU
//   alu_data, alu_carry, alu_gt, alu_eq, alu_lt : ALU results
//   op_count     : completed-response counter (only with ALU_SEQ_CNT_EN)
//
// Build option: define ALU_SEQ_CNT_EN to add the 16-bit op_count port.
// ---------------------------------------------------------------------------
module alu_vec_sequencer #(
    parameter int WIDTH   = 4,
    parameter int n_alu   = 4,
    parameter int SEL_W   = 3,
    parameter int ALU_LAT = 1
) (
    input  logic                   clk,
    input  logic                   arst,
    alu_vec_sequencer_if.slave     cmd_rsp,
    output logic [n_alu*WIDTH-1:0] alu_a,
    output logic [n_alu*WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0]       alu_select,
    output logic                   alu_enable,
    input  logic [n_alu*WIDTH-1:0] alu_data,
    input  logic [n_alu-1:0]       alu_carry,
    input  logic [n_alu-1:0]       alu_gt,
    input  logic [n_alu-1:0]       alu_eq,
    input  logic [n_alu-1:0]       alu_lt
`ifdef ALU_SEQ_CNT_EN
    ,
    output logic [15:0]            op_count
`endif
);

    localparam int DW    = n_alu * WIDTH;
    localparam int CNT_W = 4;
    // Counter loads LAT-1 so that LAT=1 captures on the first WAIT cycle.
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      alu_a_q, alu_a_d;
    logic [DW-1:0]      alu_b_q, alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic [DW-1:0]      rsp_data_q, rsp_data_d;
    logic [n_alu-1:0]   rsp_carry_q, rsp_carry_d;
    logic [n_alu-1:0]   rsp_gt_q, rsp_gt_d;
    logic [n_alu-1:0]   rsp_eq_q, rsp_eq_d;
    logic [n_alu-1:0]   rsp_lt_q, rsp_lt_d;

    // Next-state and datapath capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_gt_d    = rsp_gt_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_lt_d    = rsp_lt_q;
        case (state_q)
            IDLE: begin
                if (cmd_rsp.cmd_valid) begin
                    alu_a_d   = cmd_rsp.cmd_a;
                    alu_b_d   = cmd_rsp.cmd_b;
                    alu_sel_d = cmd_rsp.cmd_sel;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = alu_data;
                    rsp_carry_d = alu_carry;
                    rsp_gt_d    = alu_gt;
                    rsp_eq_d    = alu_eq;
                    rsp_lt_d    = alu_lt;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (cmd_rsp.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= '0;
            rsp_gt_q    <= '0;
            rsp_eq_q    <= '0;
            rsp_lt_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_gt_q    <= rsp_gt_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_lt_q    <= rsp_lt_d;
        end
    end

    // cmd_ready is gated by arst so it reads 0 for the whole reset pulse.
    assign cmd_rsp.cmd_ready = (state_q == IDLE) && arst;
    assign cmd_rsp.rsp_valid = (state_q == RESP);
    assign alu_enable        = (state_q == ISSUE);
    assign alu_a             = alu_a_q;
    assign alu_b             = alu_b_q;
    assign alu_select        = alu_sel_q;
    assign cmd_rsp.rsp_data  = rsp_data_q;
    assign cmd_rsp.rsp_carry = rsp_carry_q;
    assign cmd_rsp.rsp_gt    = rsp_gt_q;
    assign cmd_rsp.rsp_eq    = rsp_eq_q;
    assign cmd_rsp.rsp_lt    = rsp_lt_q;

`ifdef ALU_SEQ_CNT_EN
    logic [15:0] op_count_q, op_count_d;

    // Free-running count of completed response handshakes; wraps naturally.
    always_comb begin
        op_count_d = op_count_q;
        if (cmd_rsp.rsp_valid && cmd_rsp.rsp_ready) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: doc/alu_vec_sequencer.md
# alu_vec_sequencer

Command-side driver for the vector ALU. Accepts operand/opcode commands over a valid/ready handshake, drives the ALU's `a`/`b`/`select`/`enable` inputs, and waits the ALU's fixed pipeline latency. It then captures `data_out`, `carry_out` and the compare flags and returns them over a second valid/ready handshake. It is the initiator of the ALU operand interface that the ALU itself responds on, and it sits between the upstream control logic and the ALU instance.

## Interface
Parameters:
- `WIDTH`, 4: bits per lane.
- `n_alu`, 4: number of ALU lanes.
- `SEL_W`, 3: width of the ALU opcode.
- `ALU_LAT`, 1: cycles from the edge that samples `enable` to the edge on which ALU outputs are valid; legal range 1..15.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `arst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_a` in n_alu*WIDTH: lane-packed operand A; lane i is bits [i*WIDTH +: WIDTH].
- `cmd_b` in n_alu*WIDTH: lane-packed operand B.
- `cmd_sel` in SEL_W: ALU opcode.
- `alu_a` out n_alu*WIDTH: to ALU `a`.
- `alu_b` out n_alu*WIDTH: to ALU `b`.
- `alu_select` out SEL_W: to ALU `select`.
- `alu_enable` out 1: to ALU `enable`.
- `alu_data` in n_alu*WIDTH: from ALU `data_out`.
- `alu_carry` in n_alu: from ALU `carry_out`.
- `alu_gt` in n_alu: from ALU `a_greater`.
- `alu_eq` in n_alu: from ALU `a_equal`.
- `alu_lt` in n_alu: from ALU `a_less`.
- `rsp_valid` out 1: result present.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_data` out n_alu*WIDTH: captured result.
- `rsp_carry` out n_alu: captured carry flags.
- `rsp_gt` out n_alu: captured greater-than flags.
- `rsp_eq` out n_alu: captured equal flags.
- `rsp_lt` out n_alu: captured less-than flags.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`&`cmd_ready`, register `cmd_a`/`cmd_b`/`cmd_sel` into `alu_a`/`alu_b`/`alu_select` and go to ISSUE.
- ISSUE:
  - `alu_enable`=1 for exactly one cycle.
  - Load the latency counter with ALU_LAT-1 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture all `alu_*` result inputs into the `rsp_*` registers and go to RESP.
- RESP:
  - `rsp_valid`=1.
  - On `rsp_ready`, go to IDLE.
  - `rsp_*` outputs hold their value until the next capture.
- `alu_a`/`alu_b`/`alu_select` hold the last issued command outside ISSUE; they change only on command acceptance.
- Exactly one command is in flight. `cmd_ready`=0 in ISSUE, WAIT and RESP. A command is never dropped or duplicated.
- No arithmetic is performed on the data path. Widths pass through unchanged, with no truncation or extension.

## Timing
- Reset (`arst`=0, at any time including mid-operation):
  - State goes to IDLE.
  - `cmd_ready`=0 while `arst`=0, and 1 from the first cycle after release.
  - `alu_enable`=0 and `rsp_valid`=0.
  - `alu_a`, `alu_b`, `alu_select` and all `rsp_*` are 0.
  - An in-flight result is discarded.
- Command accepted at edge E0:
  - `alu_enable`=1 in the cycle after E0.
  - The ALU samples it at edge E1.
  - The result is captured at edge E1+ALU_LAT.
  - `rsp_valid` rises in the following cycle.
- Accept-to-`rsp_valid` latency is ALU_LAT+1 edges; with the default, `rsp_valid` is high 2 edges after acceptance.
- With `rsp_ready` held at 1, the response handshake completes in the first RESP cycle. IDLE is re-entered on the next edge, giving a minimum spacing of ALU_LAT+3 cycles between command acceptances.
- `rsp_ready` asserted before `rsp_valid` has no effect. `cmd_valid` outside IDLE is ignored, and the command stays pending upstream.
- The counter's end-of-count case uses no wrap-around. ALU_LAT=1 leaves WAIT on the first WAIT cycle.

## Configuration
- `ALU_SEQ_CNT_EN` defined:
  - Adds an output port `op_count`, 16 bits, reset 0.
  - It increments on each completed response handshake (`rsp_valid`&`rsp_ready`) and wraps from 0xFFFF to 0x0000.
- `ALU_SEQ_CNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
The bench uses a behavioural ALU stub: `select`=0 gives a per-lane add with carry, registered with latency ALU_LAT.
- **Reset:** pulse `arst` low for 3 cycles. Expect all outputs 0, then `cmd_ready`=1 on the first cycle after release.
- **Single op:**
  - Stimulus: `cmd_a`=16'h1234, `cmd_b`=16'h1111, `cmd_sel`=0, with `rsp_ready`=1.
  - Expect `alu_enable` high for exactly 1 cycle.
  - Expect `rsp_valid` 2 edges after acceptance with `rsp_data`=16'h2345 and `rsp_carry`=4'b0000.
- **Carry and backpressure:**
  - Stimulus: `cmd_a`=16'hF0F0, `cmd_b`=16'h1010, with `rsp_ready` held at 0 for 5 cycles.
  - Expect `rsp_data`=16'h0000 and `rsp_carry`=4'b1010, held stable.
  - Expect `cmd_ready`=0 until the handshake completes.
- **Back-to-back:**
  - Stimulus: `cmd_valid` held at 1 with 10 random commands.
  - Expect exactly 10 responses, in order, matching the stub model, with acceptances spaced 4 cycles apart.
- **Reset mid-op:** drop `arst` during WAIT. Expect `rsp_valid` never asserted for that command and state IDLE after release.
- **Counter (with ALU_SEQ_CNT_EN):** run 3 ops. Expect `op_count`=3. Force-preload 16'hFFFF and run 1 op; expect `op_count`=0.
